// File: rtl/cnn_pe_if.sv
// cnn_pe_if: host-side bundle of the 1-D convolution processing element.
//   master : host logic (drives control, pushes IFmap/filter words, pops results)
//   slave  : the processing element (cnn_pe_top)
// Signals:
//   start, stride, filter_size          control, sampled when the engine is idle
//   stall_signal                        engine waiting on an empty input or full output FIFO
//   ifmap_buffer_*  / filter_buffer_*   push side: data, write_enable, full, ready (= !full)
//   result_buffer_*                     pop side: out (fall-through head), empty, valid, read_enable
interface cnn_pe_if #(
  parameter int IFMAP_BUFFER_WIDTH  = 18,
  parameter int FILTER_BUFFER_WIDTH = 16,
  parameter int RESULT_BUFFER_WIDTH = 16,
  parameter int STRIDE_WIDTH        = 5,
  parameter int FILTER_SIZE_WIDTH   = 5
);
  logic                           start;
  logic [STRIDE_WIDTH-1:0]        stride;
  logic [FILTER_SIZE_WIDTH-1:0]   filter_size;
  logic                           stall_signal;
  logic [IFMAP_BUFFER_WIDTH-1:0]  ifmap_buffer_in;
  logic                           ifmap_buffer_write_enable;
  logic                           ifmap_buffer_full;
  logic                           ifmap_buffer_ready;
  logic [FILTER_BUFFER_WIDTH-1:0] filter_buffer_in;
  logic                           filter_buffer_write_enable;
  logic                           filter_buffer_full;
  logic                           filter_buffer_ready;
  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out;
  logic                           result_buffer_empty;
  logic                           result_buffer_valid;
  logic                           result_buffer_read_enable;

  modport master (
    output start, stride, filter_size,
    output ifmap_buffer_in, ifmap_buffer_write_enable,
    output filter_buffer_in, filter_buffer_write_enable,
    output result_buffer_read_enable,
    input  stall_signal, ifmap_buffer_full, ifmap_buffer_ready,
    input  filter_buffer_full, filter_buffer_ready,
    input  result_buffer_out, result_buffer_empty, result_buffer_valid
  );

  modport slave (
    input  start, stride, filter_size,
    input  ifmap_buffer_in, ifmap_buffer_write_enable,
    input  filter_buffer_in, filter_buffer_write_enable,
    input  result_buffer_read_enable,
    output stall_signal, ifmap_buffer_full, ifmap_buffer_ready,
    output filter_buffer_full, filter_buffer_ready,
    output result_buffer_out, result_buffer_empty, result_buffer_valid
  );
endinterface

// File: rtl/cnn_pe_top.sv
// cnn_pe_fifo: synchronous first-word fall-through FIFO with registered full/empty flags.
//   clk, rst_n (async active-low), push_i/data_i, pop_i/head_o, full_o, empty_o.
//   Pushes while full and pops while empty are dropped; push and pop together are both honoured.
// cnn_pe_top: 1-D convolution processing element.
//   clk, reset (async active-low), bus (cnn_pe_if.slave).
//   Each IFmap row is convolved with its own freshly loaded filter; one sum per window is
//   pushed into the result FIFO. Rows longer than 2**I_WIDTH-1 words are not supported.
module cnn_pe_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] STEP_C   = CW'(STEP);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && !full_q;
  assign pop_ok_s  = pop_i && !empty_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  // Next pointers (wrapping at DEPTH, which need not be a power of two) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + STEP_C;
      2'b01:   cnt_d = cnt_q - STEP_C;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == DEPTH_C);
      empty_q  <= (cnt_d == '0);
    end
  end
endmodule

module cnn_pe_top #(
  parameter int IFMAP_BUFFER_WIDTH      = 18,
  parameter int IF_ADDR_WIDTH           = 4,
  parameter int IF_PAD_LENGTH           = 12,
  parameter int IF_BUFFER_COLUMNS       = 12,
  parameter int IF_BUFFER_PAR_WRITE     = 1,
  parameter int FILTER_BUFFER_WIDTH     = 16,
  parameter int FILTER_SIZE_WIDTH       = 5,
  parameter int FILTER_ADDR_WIDTH       = 4,
  parameter int FILTER_PAD_LENGTH       = 16,
  parameter int FILTER_BUFFER_COLUMNS   = 16,
  parameter int FILTER_BUFFER_PAR_WRITE = 1,
  parameter int RESULT_BUFFER_WIDTH     = 16,
  parameter int RESULT_BUFFER_COLUMNS   = 64,
  parameter int RESULT_BUFFER_PAR_READ  = 1,
  parameter int ADD_OUT_WIDTH           = 16,
  parameter int MULT_WIDTH              = 32,
  parameter int STRIDE_WIDTH            = 5,
  parameter int I_WIDTH                 = 5
) (
  input logic     clk,
  input logic     reset,
  cnn_pe_if.slave bus
);
  localparam int DW     = IFMAP_BUFFER_WIDTH - 2;
  localparam int FS_MAX = (IF_PAD_LENGTH < FILTER_PAD_LENGTH) ? IF_PAD_LENGTH : FILTER_PAD_LENGTH;
  localparam logic [FILTER_SIZE_WIDTH-1:0] FS_MAX_C = FILTER_SIZE_WIDTH'(FS_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FILT = 3'd1,
    FILL      = 3'd2,
    MAC       = 3'd3,
    WRITE     = 3'd4,
    NEXT_ROW  = 3'd5
  } state_t;

  // Row position -> circular pad slot; positions never exceed 4*IF_PAD_LENGTH here.
  function automatic logic [IF_ADDR_WIDTH-1:0] wrap_if(input logic [7:0] pos);
    logic [7:0] v;
    v = pos;
    for (int i = 0; i < 4; i++) begin
      if (v >= 8'(IF_PAD_LENGTH)) begin
        v = v - 8'(IF_PAD_LENGTH);
      end else begin
        v = v;
      end
    end
    return IF_ADDR_WIDTH'(v);
  endfunction

  state_t                         state_q, state_d;
  logic [STRIDE_WIDTH-1:0]        stride_q, stride_d;
  logic [FILTER_SIZE_WIDTH-1:0]   fs_q, fs_d;
  logic [I_WIDTH-1:0]             p_q, p_d;       // row position of the current window
  logic [I_WIDTH-1:0]             rcv_q, rcv_d;   // words of the current row received so far
  logic                           end_q, end_d;   // end-flag word of the current row received
  logic [FILTER_ADDR_WIDTH-1:0]   k_q, k_d;       // tap index (filter load and MAC)
  logic [ADD_OUT_WIDTH-1:0]       acc_q, acc_d;
  logic [DW-1:0]                  if_pad_q [IF_PAD_LENGTH];
  logic [FILTER_BUFFER_WIDTH-1:0] f_pad_q  [FILTER_PAD_LENGTH];

  logic [IFMAP_BUFFER_WIDTH-1:0]  ifm_head_s;
  logic                           ifm_full_s, ifm_empty_s, ifm_pop_s;
  logic [FILTER_BUFFER_WIDTH-1:0] flt_head_s;
  logic                           flt_full_s, flt_empty_s, flt_pop_s;
  logic [RESULT_BUFFER_WIDTH-1:0] res_head_s;
  logic                           res_full_s, res_empty_s, res_push_s;
  logic                           stall_s, cfg_ok_s, last_tap_s, win_ready_s;
  logic                           if_wr_en_s, f_wr_en_s;
  logic [IF_ADDR_WIDTH-1:0]       if_wr_idx_s, if_rd_idx_s;
  logic [I_WIDTH:0]               win_end_s, p_sum_s;
  logic [MULT_WIDTH-1:0]          prod_s;

  cnn_pe_fifo #(.WIDTH(IFMAP_BUFFER_WIDTH), .DEPTH(IF_BUFFER_COLUMNS), .STEP(IF_BUFFER_PAR_WRITE)) u_ifm_fifo (
    .clk(clk), .rst_n(reset), .push_i(bus.ifmap_buffer_write_enable), .data_i(bus.ifmap_buffer_in),
    .pop_i(ifm_pop_s), .head_o(ifm_head_s), .full_o(ifm_full_s), .empty_o(ifm_empty_s));

  cnn_pe_fifo #(.WIDTH(FILTER_BUFFER_WIDTH), .DEPTH(FILTER_BUFFER_COLUMNS), .STEP(FILTER_BUFFER_PAR_WRITE)) u_flt_fifo (
    .clk(clk), .rst_n(reset), .push_i(bus.filter_buffer_write_enable), .data_i(bus.filter_buffer_in),
    .pop_i(flt_pop_s), .head_o(flt_head_s), .full_o(flt_full_s), .empty_o(flt_empty_s));

  cnn_pe_fifo #(.WIDTH(RESULT_BUFFER_WIDTH), .DEPTH(RESULT_BUFFER_COLUMNS), .STEP(RESULT_BUFFER_PAR_READ)) u_res_fifo (
    .clk(clk), .rst_n(reset), .push_i(res_push_s), .data_i(RESULT_BUFFER_WIDTH'(acc_q)),
    .pop_i(bus.result_buffer_read_enable), .head_o(res_head_s), .full_o(res_full_s), .empty_o(res_empty_s));

  assign bus.ifmap_buffer_full   = ifm_full_s;
  assign bus.ifmap_buffer_ready  = !ifm_full_s;
  assign bus.filter_buffer_full  = flt_full_s;
  assign bus.filter_buffer_ready = !flt_full_s;
  assign bus.result_buffer_out   = res_head_s;
  assign bus.result_buffer_empty = res_empty_s;
  assign bus.result_buffer_valid = !res_empty_s;
  assign bus.stall_signal        = stall_s;

  assign cfg_ok_s    = (bus.stride != '0) && (bus.filter_size != '0) && (bus.filter_size <= FS_MAX_C);
  assign last_tap_s  = (FILTER_SIZE_WIDTH'(k_q) == (fs_q - FILTER_SIZE_WIDTH'(1'b1)));
  assign win_end_s   = (I_WIDTH+1)'(p_q) + (I_WIDTH+1)'(fs_q);
  assign win_ready_s = ((I_WIDTH+1)'(rcv_q) >= win_end_s);
  assign p_sum_s     = (I_WIDTH+1)'(p_q) + (I_WIDTH+1)'(stride_q);
  assign if_rd_idx_s = wrap_if(8'(p_q) + 8'(k_q));
  assign prod_s      = MULT_WIDTH'(if_pad_q[if_rd_idx_s]) * MULT_WIDTH'(f_pad_q[k_q]);

  // Sequencer: next state, FIFO pops/pushes, pad writes and stall.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    fs_d        = fs_q;
    p_d         = p_q;
    rcv_d       = rcv_q;
    end_d       = end_q;
    k_d         = k_q;
    acc_d       = acc_q;
    ifm_pop_s   = 1'b0;
    flt_pop_s   = 1'b0;
    res_push_s  = 1'b0;
    stall_s     = 1'b0;
    if_wr_en_s  = 1'b0;
    if_wr_idx_s = '0;
    f_wr_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && cfg_ok_s) begin
          stride_d = bus.stride;
          fs_d     = bus.filter_size;
          k_d      = '0;
          state_d  = LOAD_FILT;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD_FILT: begin
        if (flt_empty_s) begin
          stall_s = 1'b1;
        end else begin
          flt_pop_s = 1'b1;
          f_wr_en_s = 1'b1;
          if (last_tap_s) begin
            k_d     = '0;
            p_d     = '0;
            rcv_d   = '0;
            end_d   = 1'b0;
            state_d = FILL;
          end else begin
            k_d = k_q + FILTER_ADDR_WIDTH'(1'b1);
          end
        end
      end
      FILL: begin
        if (win_ready_s) begin
          k_d     = '0;
          state_d = MAC;
        end else if (end_q) begin
          state_d = NEXT_ROW;
        end else if (ifm_empty_s) begin
          stall_s = 1'b1;
        end else begin
          ifm_pop_s  = 1'b1;
          if_wr_en_s = 1'b1;
          end_d      = ifm_head_s[IFMAP_BUFFER_WIDTH-2];
          if (ifm_head_s[IFMAP_BUFFER_WIDTH-1]) begin
            // Start flag: this word is position 0 of a new row, earlier words are dropped.
            p_d         = '0;
            rcv_d       = I_WIDTH'(1'b1);
            if_wr_idx_s = '0;
          end else begin
            // Words below p land in freed slots; the write is harmless.
            rcv_d       = (rcv_q == '1) ? rcv_q : rcv_q + I_WIDTH'(1'b1);
            if_wr_idx_s = wrap_if(8'(rcv_q));
          end
        end
      end
      MAC: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + ADD_OUT_WIDTH'(prod_s);
        if (last_tap_s) begin
          state_d = WRITE;
        end else begin
          k_d = k_q + FILTER_ADDR_WIDTH'(1'b1);
        end
      end
      WRITE: begin
        if (res_full_s) begin
          stall_s = 1'b1;
        end else begin
          res_push_s = 1'b1;
          // Saturating p keeps an oversized stride from wrapping back into the row.
          p_d        = p_sum_s[I_WIDTH] ? '1 : p_sum_s[I_WIDTH-1:0];
          state_d    = FILL;
        end
      end
      NEXT_ROW: begin
        k_d     = '0;
        state_d = LOAD_FILT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers and scratchpads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      stride_q <= '0;
      fs_q     <= '0;
      p_q      <= '0;
      rcv_q    <= '0;
      end_q    <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      for (int i = 0; i < IF_PAD_LENGTH; i++) begin
        if_pad_q[i] <= '0;
      end
      for (int i = 0; i < FILTER_PAD_LENGTH; i++) begin
        f_pad_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      fs_q     <= fs_d;
      p_q      <= p_d;
      rcv_q    <= rcv_d;
      end_q    <= end_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      if (if_wr_en_s) begin
        if_pad_q[if_wr_idx_s] <= ifm_head_s[DW-1:0];
      end
      if (f_wr_en_s) begin
        f_pad_q[k_q] <= flt_head_s;
      end
    end
  end
endmodule

// File: tb/tb_cnn_pe_top.sv
module tb_cnn_pe_top;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_pe_if bus ();
  cnn_pe_top u_dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [1:0] NF = 2'b00;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] EN = 2'b01;
  localparam logic [1:0] SE = 2'b11;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops every result the DUT presents and compares it with the scoreboard.
  initial begin
    logic [15:0] e;
    bus.result_buffer_read_enable = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.result_buffer_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL result_unexpected: got 0x%0h, required no result", bus.result_buffer_out);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(bus.result_buffer_out), 32'(e));
        end
        bus.result_buffer_read_enable = 1'b1;
      end else begin
        bus.result_buffer_read_enable = 1'b0;
      end
    end
  end

  task automatic push_if(input logic [1:0] fl, input logic [15:0] d);
    bus.ifmap_buffer_in = {fl, d};
    bus.ifmap_buffer_write_enable = 1'b1;
    @(negedge clk);
    bus.ifmap_buffer_write_enable = 1'b0;
  endtask

  task automatic push_flt(input logic [15:0] d);
    bus.filter_buffer_in = d;
    bus.filter_buffer_write_enable = 1'b1;
    @(negedge clk);
    bus.filter_buffer_write_enable = 1'b0;
  endtask

  task automatic push_filter4(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
    push_flt(a); push_flt(b); push_flt(c); push_flt(d);
  endtask

  task automatic start_pe(input logic [4:0] s, input logic [4:0] fs);
    bus.start = 1'b1;
    bus.stride = s;
    bus.filter_size = fs;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.stride = 5'd0;
    bus.filter_size = 5'd0;
    bus.ifmap_buffer_in = 18'd0;
    bus.ifmap_buffer_write_enable = 1'b0;
    bus.filter_buffer_in = 16'd0;
    bus.filter_buffer_write_enable = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.stall_signal), 32'd0);
    check("rst_if_full", 32'(bus.ifmap_buffer_full), 32'd0);
    check("rst_if_ready", 32'(bus.ifmap_buffer_ready), 32'd1);
    check("rst_flt_ready", 32'(bus.filter_buffer_ready), 32'd1);
    check("rst_res_empty", 32'(bus.result_buffer_empty), 32'd1);
    check("rst_res_valid", 32'(bus.result_buffer_valid), 32'd0);
    check("rst_res_out", 32'(bus.result_buffer_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Invalid configurations must leave the engine idle (no stall on the empty filter FIFO).
    start_pe(5'd0, 5'd4);
    start_pe(5'd1, 5'd13);
    start_pe(5'd1, 5'd0);
    repeat (3) @(negedge clk);
    check("bad_cfg_idle_stall", 32'(bus.stall_signal), 32'd0);

    // Basic row plus further rows, each with a fresh filter.
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    push_if(ST, 16'd5); push_if(NF, 16'd6); push_if(NF, 16'd7); push_if(EN, 16'd8);
    exp_q.push_back(16'd70);
    start_pe(5'd4, 5'd4);
    drain("row1_drained");
    exp_q.push_back(16'd10);
    push_filter4(16'd1, 16'd1, 16'd1, 16'd1);
    push_if(ST, 16'd1); push_if(NF, 16'd2); push_if(NF, 16'd3); push_if(EN, 16'd4);
    drain("row2_drained");
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    push_if(ST, 16'd1); push_if(NF, 16'd2); push_if(EN, 16'd3);
    repeat (10) @(negedge clk);
    exp_q.push_back(16'd8);
    push_filter4(16'd1, 16'd1, 16'd1, 16'd1);
    push_if(ST, 16'd2); push_if(NF, 16'd2); push_if(NF, 16'd2); push_if(EN, 16'd2);
    drain("row4_drained");

    // Stride 1 and stride 2 over a 6-word row.
    do_reset();
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 1; i <= 6; i++) push_if((i == 1) ? ST : ((i == 6) ? EN : NF), 16'(i));
    exp_q.push_back(16'd30); exp_q.push_back(16'd40); exp_q.push_back(16'd50);
    start_pe(5'd1, 5'd4);
    drain("stride1_drained");
    do_reset();
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 1; i <= 6; i++) push_if((i == 1) ? ST : ((i == 6) ? EN : NF), 16'(i));
    exp_q.push_back(16'd30); exp_q.push_back(16'd50);
    start_pe(5'd2, 5'd4);
    drain("stride2_drained");

    // IFmap FIFO full: 12 words fill it, the 13th is dropped.
    do_reset();
    for (int i = 1; i <= 12; i++) push_if((i == 1) ? ST : ((i == 12) ? EN : NF), 16'(i));
    check("full_after12", 32'(bus.ifmap_buffer_full), 32'd1);
    check("ready_after12", 32'(bus.ifmap_buffer_ready), 32'd0);
    check("res_valid_idle", 32'(bus.result_buffer_valid), 32'd0);
    push_if(SE, 16'd99);
    check("full_after13", 32'(bus.ifmap_buffer_full), 32'd1);
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    exp_q.push_back(16'd30); exp_q.push_back(16'd70); exp_q.push_back(16'd110);
    start_pe(5'd4, 5'd4);
    drain("full_drained");

    // Accumulator wrap: four products of 0xFFFE0001 keep only 0x0001 each.
    do_reset();
    push_filter4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    push_if(ST, 16'hFFFF); push_if(NF, 16'hFFFF); push_if(NF, 16'hFFFF); push_if(EN, 16'hFFFF);
    exp_q.push_back(16'h0004);
    start_pe(5'd4, 5'd4);
    drain("wrap_drained");

    // Stall while the filter FIFO is empty, released by filter words.
    do_reset();
    start_pe(5'd4, 5'd4);
    repeat (3) @(negedge clk);
    check("stall_no_filter_a", 32'(bus.stall_signal), 32'd1);
    repeat (3) @(negedge clk);
    check("stall_no_filter_b", 32'(bus.stall_signal), 32'd1);
    push_flt(16'd1);
    check("stall_filter_arrived", 32'(bus.stall_signal), 32'd0);
    push_flt(16'd2); push_flt(16'd3); push_flt(16'd4);
    repeat (2) @(negedge clk);
    check("stall_no_ifmap", 32'(bus.stall_signal), 32'd1);
    exp_q.push_back(16'd70);
    push_if(ST, 16'd5); push_if(NF, 16'd6); push_if(NF, 16'd7); push_if(EN, 16'd8);
    drain("stall_drained");

    // Reset in the middle of MAC: no result, FIFOs cleared, restart works.
    do_reset();
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    for (int i = 1; i <= 6; i++) push_if((i == 1) ? ST : ((i == 6) ? EN : NF), 16'(i));
    start_pe(5'd1, 5'd4);
    repeat (11) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_res_empty", 32'(bus.result_buffer_empty), 32'd1);
    check("midrst_if_ready", 32'(bus.ifmap_buffer_ready), 32'd1);
    check("midrst_stall", 32'(bus.stall_signal), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_no_result", 32'(bus.result_buffer_valid), 32'd0);
    push_filter4(16'd1, 16'd2, 16'd3, 16'd4);
    push_if(ST, 16'd5); push_if(NF, 16'd6); push_if(NF, 16'd7); push_if(EN, 16'd8);
    exp_q.push_back(16'd70);
    start_pe(5'd4, 5'd4);
    drain("restart_drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
